// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store access unit between a core and a byte memory
//
// Purpose: accepts one load/store request at a time, computes the effective
// address, screens it for opcode/range/alignment errors, performs a single
// one-cycle memory access and returns the (merged) load result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reqValid/reqReady request handshake
//   reqOp             opcode (LB..SWR), reqBase + signed reqOffset = EA
//   reqStoreData      store data, or rt merge value for LWL/LWR
//   memAddress/memData/memWriteMode/memReadMode/memUnsignedLoad
//                     memory-side access controls, active only in ACCESS
//   memDataOutput     combinational read data from the memory
//   respValid/respReady response handshake
//   respData/respError load result (0 for stores/errors), error flag
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [3:0]  reqOp,
  input  logic [31:0] reqBase,
  input  logic [15:0] reqOffset,
  input  logic [31:0] reqStoreData,
  output logic [31:0] memAddress,
  output logic [31:0] memData,
  output logic [2:0]  memWriteMode,
  output logic [2:0]  memReadMode,
  output logic        memUnsignedLoad,
  input  logic [31:0] memDataOutput,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respError
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_BYTE  = 3'd1;
  localparam logic [2:0] MODE_HALF  = 3'd2;
  localparam logic [2:0] MODE_WORD  = 3'd3;
  localparam logic [2:0] MODE_WLEFT = 3'd4;
  localparam logic [2:0] MODE_WRIGHT = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  op_q;
  logic [31:0] ea_q;
  logic [31:0] rt_q;
  logic [31:0] resp_data_q;
  logic        resp_error_q;

  logic [31:0] ea;
  logic        accept;
  logic        req_err;
  logic [31:0] load_result;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;

  // Loads and stores share the access-width mapping; op[3] selects direction.
  function automatic logic [2:0] op_mode(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_mode = MODE_BYTE;
      OP_LH, OP_LHU, OP_SH: op_mode = MODE_HALF;
      OP_LW, OP_SW:         op_mode = MODE_WORD;
      OP_LWL, OP_SWL:       op_mode = MODE_WLEFT;
      OP_LWR, OP_SWR:       op_mode = MODE_WRIGHT;
      default:              op_mode = MODE_NONE;
    endcase
  endfunction

  assign ea     = reqBase + {{16{reqOffset[15]}}, reqOffset};
  assign accept = reqValid && reqReady;

  always_comb begin
    req_err = 1'b0;
    if (op_mode(reqOp) == MODE_NONE)
      req_err = 1'b1;
    if (ea[31:16] != 16'h0000)
      req_err = 1'b1;
    if ((reqOp == OP_LH || reqOp == OP_LHU || reqOp == OP_SH) && ea[0])
      req_err = 1'b1;
    if ((reqOp == OP_LW || reqOp == OP_SW) && (ea[1:0] != 2'b00))
      req_err = 1'b1;
  end

  // Byte-lane masks selecting the captured memory word; the rest comes from rt.
  // For LWL the captured word supplies the top k+1 bytes (shift by 3-k = ~k),
  // for LWR it supplies the bottom 4-k bytes.
  assign lwl_mask = 32'hFFFF_FFFF << {~ea_q[1:0], 3'b000};
  assign lwr_mask = 32'hFFFF_FFFF >> {ea_q[1:0], 3'b000};

  always_comb begin
    load_result = 32'h0;
    case (op_q)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:
        load_result = memDataOutput;
      OP_LWL:
        load_result = (memDataOutput & lwl_mask) | (rt_q & ~lwl_mask);
      OP_LWR:
        load_result = (memDataOutput & lwr_mask) | (rt_q & ~lwr_mask);
      default:
        load_result = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and response data; load data is taken at the edge that ends ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 4'h0;
      ea_q         <= 32'h0;
      rt_q         <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
    end else if (accept) begin
      op_q         <= reqOp;
      ea_q         <= ea;
      rt_q         <= reqStoreData;
      resp_data_q  <= 32'h0;
      resp_error_q <= req_err;
    end else if (state == ACCESS) begin
      resp_data_q  <= load_result;
    end
  end

  // Output logic; memory controls are forced idle whenever rst is high so a
  // reset landing in ACCESS cancels the write in that same cycle.
  always_comb begin
    memAddress      = 32'h0;
    memData         = 32'h0;
    memWriteMode    = MODE_NONE;
    memReadMode     = MODE_NONE;
    memUnsignedLoad = 1'b0;
    reqReady        = (state == IDLE) && !rst;
    respValid       = (state == RESP);
    if (state == ACCESS && !rst) begin
      memAddress = ea_q;
      if (op_q[3]) begin
        memWriteMode = op_mode(op_q);
        memData      = rt_q;
      end else begin
        memReadMode     = op_mode(op_q);
        memUnsignedLoad = (op_q == OP_LBU) || (op_q == OP_LHU);
      end
    end
  end

  assign respData  = resp_data_q;
  assign respError = resp_error_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- reqValid  in  1  core request valid.
- reqReady  out  1  block can accept a request.
- reqOp  in  4  opcode: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; any other value is illegal.
- reqBase  in  32  base register value.
- reqOffset  in  16  signed immediate offset.
- reqStoreData  in  32  store data, or the rt merge value for LWL/LWR.
- memAddress  out  32  address to the memory.
- memData  out  32  write data to the memory.
- memWriteMode  out  3  NONE=0, BYTE=1, HALFWORD=2, WORD=3, WORDLEFT=4, WORDRIGHT=5.
- memReadMode  out  3  same encoding as memWriteMode.
- memUnsignedLoad  out  1  zero-extend select.
- memDataOutput  in  32  combinational read data from the memory.
- respValid  out  1  response valid.
- respReady  in  1  core accepts the response.
- respData  out  32  load result; 0 for stores and errors.
- respError  out  1  address or opcode error.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-004 reqReady SHALL be 1 only in IDLE and rst=0.
REQ-005 A request SHALL be accepted on a cycle with reqValid=1 and reqReady=1; on acceptance the block SHALL register reqOp, reqStoreData and the effective address EA = reqBase + sign-extended reqOffset, wrapping modulo 2^32.
REQ-006 The request SHALL be flagged as an error if any of these hold:
- reqOp is illegal;
- EA[31:16] != 0;
- LH, LHU or SH with EA[0]=1;
- LW or SW with EA[1:0] != 0.
LWL, LWR, SWL, SWR, LB, LBU and SB never raise an alignment error.
REQ-007 On an accepted error request, the next state SHALL be RESP with respError=1 and respData=0, and no memory access SHALL be made.
REQ-008 On an accepted legal request, the next state SHALL be ACCESS.
REQ-009 ACCESS SHALL last exactly one cycle; the next state SHALL be RESP.
REQ-010 In ACCESS the block SHALL drive:
- memAddress = EA;
- memReadMode = BYTE, HALFWORD, WORD, WORDLEFT or WORDRIGHT for loads, and NONE otherwise;
- memWriteMode = the corresponding mode for stores, and NONE otherwise;
- memData = reqStoreData for stores, and 0 otherwise;
- memUnsignedLoad = 1 only for LBU and LHU.
REQ-011 Outside ACCESS, and in any cycle with rst=1, memWriteMode and memReadMode SHALL be NONE, memAddress=0, memData=0 and memUnsignedLoad=0.
REQ-012 Load data SHALL be captured from memDataOutput at the clock edge that ends ACCESS.
REQ-013 For LB, LBU, LH, LHU and LW, respData SHALL equal the captured data.
REQ-014 For LWL with k=EA[1:0], respData SHALL take bytes [3:3-k] from the captured data and bytes [2-k:0] from the rt merge value (k=3 gives the whole captured word).
REQ-015 For LWR with k=EA[1:0], respData SHALL take bytes [3-k:0] from the captured data and bytes [3:4-k] from the rt merge value (k=0 gives the whole captured word).
REQ-016 For stores, respData SHALL be 0.
REQ-017 Latency SHALL be: acceptance at cycle N, memory access at N+1, respValid=1 at N+2; for error requests, respValid=1 at N+1.
REQ-018 In RESP, respValid=1; respData and respError SHALL hold stable until respValid=1 and respReady=1, after which the next state SHALL be IDLE.
REQ-019 A new request SHALL NOT be accepted in the same cycle that a response completes; no request pipelining, one request outstanding at a time.
REQ-020 Exactly one memory write cycle SHALL occur per legal store request, including under respReady stall.

Reset
REQ-021 In a cycle with rst=1 the block SHALL enter IDLE at the next edge with all outputs low except the combinational forcing of REQ-011; reset values: respValid=0, respData=0, respError=0, reqReady=0 during rst and 1 after.
REQ-022 A reset asserted in ACCESS SHALL suppress the write in that cycle (memWriteMode=NONE) and discard the request; no response SHALL be produced.
REQ-023 A reset asserted in RESP SHALL drop respValid at the next edge.

Verification
REQ-024 SW reqBase=0x100, reqOffset=4, data=0xDEADBEEF, then LW same address -> write cycle has memWriteMode=3, memAddress=0x104; LW respData=0xDEADBEEF at N+2.
REQ-025 Memory bytes at 0x200..0x203 = 0x11,0x22,0x33,0x44 (LSB first); LWL at EA=0x201 with rt=0xAABBCCDD -> respData=0x2211CCDD; LWR at EA=0x202 with rt=0xAABBCCDD -> respData=0xAABB4433.
REQ-026 Byte 0x80 at 0x10: LB -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-027 LW at EA=0x102 -> respError=1 at N+1, memReadMode and memWriteMode stay NONE throughout; LB at EA=0x00010000 -> respError=1; reqOp=7 -> respError=1.
REQ-028 Hold respReady=0 for 5 cycles after a SW response -> respValid stays 1, reqReady stays 0, and exactly one write cycle is observed.
REQ-029 Assert rst in the ACCESS cycle of an SB to 0x300 -> memWriteMode=NONE in that cycle, byte 0x300 unchanged, no respValid, reqReady=1 the cycle after rst deasserts.
